// File: rtl/cpu_run_ctrl.sv
// Run controller for a small CPU core: loads an 8-word program into instruction memory, then
// resets the core and issues RUN_CYCLES instructions. Define CPU_RUN_CTRL_SINGLE_STEP_EN for single-step.
module cpu_run_ctrl #(
   parameter int unsigned RUN_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_start,
   input  logic       load_valid,
   input  logic [2:0] load_data,
   output logic       load_ready,
   input  logic       run_start,
   input  logic       abort,
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
   input  logic       step_req,
`endif
   output logic       imem_we,
   output logic [2:0] imem_addr,
   output logic [2:0] imem_wdata,
   output logic       core_reset,
   output logic       core_en,
   output logic       busy,
   output logic       done,
   output logic [3:0] exec_count
);

   localparam int unsigned AW = 3;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LAST_CNT = CW'(RUN_CYCLES - 1);
   localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLR,
      S_RUN,
      S_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [AW-1:0]  wr_ptr;
   logic           issue_ok;

`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
   // One issue slot in the cycle after each rising edge of step_req
   logic step_q;
   logic step_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q    <= 1'b0;
         step_edge <= 1'b0;
      end else begin
         step_q    <= step_req;
         step_edge <= step_req & ~step_q;
      end
   end

   assign issue_ok = step_edge;
`else
   assign issue_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (load_start) begin
               state_nxt = S_LOAD;
            end else if (run_start) begin
               state_nxt = S_CLR;
            end
         end
         S_LOAD: begin
            if (abort || (imem_we && (wr_ptr == LAST_PTR))) begin
               state_nxt = S_IDLE;
            end
         end
         S_CLR: state_nxt = S_RUN;
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (core_en && (exec_count == LAST_CNT)) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the write port follows load_valid within the cycle
   always_comb begin
      load_ready = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      core_reset = 1'b0;
      core_en    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_LOAD: begin
            busy       = 1'b1;
            load_ready = 1'b1;
            if (load_valid) begin
               imem_we    = 1'b1;
               imem_addr  = wr_ptr;
               imem_wdata = load_data;
            end
         end
         S_CLR: begin
            busy       = 1'b1;
            core_reset = 1'b1;
         end
         S_RUN: begin
            busy    = 1'b1;
            core_en = issue_ok;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Write pointer and issued-instruction counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         exec_count <= '0;
      end else begin
         if ((state == S_LOAD) && abort) begin
            wr_ptr <= '0;
         end else if (imem_we) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (state == S_CLR) begin
            exec_count <= '0;
         end else if (core_en) begin
            exec_count <= exec_count + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: scenario tasks with randomized data, gaps and abort points,
// checked against pointer/count expectations derived from the load and run rules.
module tb_cpu_run_ctrl;

   localparam int unsigned RC = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_start;
   logic       load_valid;
   logic [2:0] load_data;
   logic       load_ready;
   logic       run_start;
   logic       abort;
   logic       imem_we;
   logic [2:0] imem_addr;
   logic [2:0] imem_wdata;
   logic       core_reset;
   logic       core_en;
   logic       busy;
   logic       done;
   logic [3:0] exec_count;
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
   logic       step_req;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int mptr;

   cpu_run_ctrl #(.RUN_CYCLES(RC)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .run_start  (run_start),
      .abort      (abort),
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
      .step_req   (step_req),
`endif
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .core_en    (core_en),
      .busy       (busy),
      .done       (done),
      .exec_count (exec_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_start = 1'b1; run_start = 1'b1; load_valid = 1'b1; abort = 1'b0;
      load_data = 3'b101;
      cyc(); settle();
      n_cmp++;
      if ({busy, done, core_en, core_reset, imem_we, load_ready, imem_addr, imem_wdata, exec_count} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_during got %b/%b/%b/%b/%b/%b a=%0d d=%0d cnt=%0d want all 0", busy, done,
                  core_en, core_reset, imem_we, load_ready, imem_addr, imem_wdata, exec_count);
      end
      load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0;
      reset = 1'b0;
      cyc(); settle();
      n_cmp++;
      if ({busy, done, core_en, core_reset, imem_we, load_ready, imem_addr, imem_wdata, exec_count} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_after got busy=%b done=%b en=%b cr=%b we=%b rdy=%b cnt=%0d want all 0",
                  busy, done, core_en, core_reset, imem_we, load_ready, exec_count);
      end
   endtask

   // Load nwords words; stall_w gets a 3-cycle gap, abort_w (>=0) aborts on that word.
   task automatic do_load(input int nwords, input int abort_w, input int stall_w, input bit rnd);
      logic [2:0] d;
      int         g;
      bit         ab;
      load_start = 1'b1; cyc(); load_start = 1'b0;
      mptr = 0;
      for (int w = 0; w < nwords; w++) begin
         g = (w == stall_w) ? 3 : (rnd ? int'($urandom_range(0, 2)) : 0);
         for (int i = 0; i < g; i++) begin
            load_valid = 1'b0; load_data = 3'($urandom);
            load_start = 1'($urandom); run_start = 1'($urandom);
            settle();
            n_cmp++;
            if ({load_ready, busy, imem_we, imem_wdata} !== 6'b110000) begin
               n_err++;
               $display("FAIL load_gap w=%0d got rdy=%b busy=%b we=%b wd=%0d want 1 1 0 0",
                        w, load_ready, busy, imem_we, imem_wdata);
            end
            cyc();
         end
         d  = rnd ? 3'($urandom) : 3'(w);
         ab = (w == abort_w);
         load_valid = 1'b1; load_data = d; abort = ab; load_start = 1'b0; run_start = 1'b0;
         settle();
         n_cmp++;
         if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 3'(mptr), d}) begin
            n_err++;
            $display("FAIL load_word w=%0d got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d",
                     w, imem_we, imem_addr, imem_wdata, mptr, d);
         end
         cyc();
         mptr = (mptr + 1) % 8;
         abort = 1'b0; load_valid = 1'b0;
         if (ab) begin
            mptr = 0;
            break;
         end
      end
      if ((nwords == 8) || (abort_w >= 0 && abort_w < nwords)) begin
         settle();
         n_cmp++;
         if ({busy, load_ready, imem_we, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL load_end got busy=%b rdy=%b we=%b done=%b want idle", busy, load_ready, imem_we, done);
         end
      end
   endtask

`ifndef CPU_RUN_CTRL_SINGLE_STEP_EN
   // Run; abort_at in 1..RC aborts in that RUN cycle, 0 means run to completion.
   task automatic do_run(input int abort_at, input bit clr_abort);
      int  exp_cnt;
      bit  exp_done;
      run_start = 1'b1; cyc(); run_start = 1'b0; abort = clr_abort;
      settle();
      n_cmp++;
      if ({core_reset, core_en, busy, done} !== 4'b1010) begin
         n_err++;
         $display("FAIL run_clr got cr=%b en=%b busy=%b done=%b want 1 0 1 0", core_reset, core_en, busy, done);
      end
      cyc(); abort = 1'b0;
      for (int k = 1; k <= int'(RC); k++) begin
         abort = (k == abort_at); run_start = 1'($urandom); load_start = 1'($urandom);
         settle();
         n_cmp++;
         if ({core_en, core_reset, busy, exec_count} !== {3'b101, 4'(k - 1)}) begin
            n_err++;
            $display("FAIL run_cycle k=%0d got en=%b cr=%b busy=%b cnt=%0d want 1 0 1 %0d",
                     k, core_en, core_reset, busy, exec_count, k - 1);
         end
         cyc();
         abort = 1'b0; run_start = 1'b0; load_start = 1'b0;
         if (k == abort_at) break;
      end
      exp_done = !(abort_at >= 1 && abort_at <= int'(RC));
      exp_cnt  = exp_done ? int'(RC) : abort_at;
      for (int h = 0; h < 2; h++) begin
         settle();
         n_cmp++;
         if ({core_en, busy, done, exec_count} !== {2'b00, exp_done, 4'(exp_cnt)}) begin
            n_err++;
            $display("FAIL run_end h=%0d got en=%b busy=%b done=%b cnt=%0d want 0 0 %b %0d",
                     h, core_en, busy, done, exec_count, exp_done, exp_cnt);
         end
         abort = 1'b1; cyc(); abort = 1'b0;
      end
   endtask

   task automatic test_priority();
      load_start = 1'b1; run_start = 1'b1; cyc(); load_start = 1'b0; run_start = 1'b0;
      settle();
      n_cmp++;
      if ({load_ready, core_reset} !== 2'b10) begin
         n_err++;
         $display("FAIL priority got rdy=%b cr=%b want 1 0", load_ready, core_reset);
      end
      abort = 1'b1; cyc(); abort = 1'b0; settle();
      n_cmp++;
      if ({busy, load_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL priority_abort got busy=%b rdy=%b want 0 0", busy, load_ready);
      end
   endtask

   task automatic test_reset_midrun();
      run_start = 1'b1; cyc(); run_start = 1'b0; cyc(); cyc();
      reset = 1'b1; settle();
      n_cmp++;
      if ({busy, core_en, done, exec_count} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_midrun got busy=%b en=%b done=%b cnt=%0d want 0", busy, core_en, done, exec_count);
      end
      cyc(); reset = 1'b0; cyc();
   endtask
`else
   task automatic test_step();
      int cnt = 0;
      step_req = 1'b0;
      run_start = 1'b1; cyc(); run_start = 1'b0; cyc();
      for (int c = 0; c < 24; c++) begin
         step_req = (c == 0 || c == 3 || c == 6 || c >= 9);
         settle();
         if (core_en) cnt++;
         cyc();
      end
      n_cmp++;
      if ({4'(cnt), exec_count} !== {4'd4, 4'd4}) begin
         n_err++;
         $display("FAIL step_count got en_cycles=%0d cnt=%0d want 4 4", cnt, exec_count);
      end
      abort = 1'b1; cyc(); abort = 1'b0; step_req = 1'b0; settle();
      n_cmp++;
      if ({busy, core_en} !== 2'b00) begin
         n_err++;
         $display("FAIL step_abort got busy=%b en=%b want 0 0", busy, core_en);
      end
   endtask
`endif

   task automatic test_reset_midload();
      do_load(5, -1, -1, 1'b0);
      load_valid = 1'b1; load_data = 3'd5; settle();
      reset = 1'b1; settle();
      n_cmp++;
      if ({busy, done, core_en, core_reset, imem_we, load_ready, imem_addr, imem_wdata, exec_count} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_midload got busy=%b we=%b rdy=%b a=%0d d=%0d want all 0",
                  busy, imem_we, load_ready, imem_addr, imem_wdata);
      end
      cyc(); reset = 1'b0; load_valid = 1'b0; cyc();
      do_load(8, -1, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
`ifndef CPU_RUN_CTRL_SINGLE_STEP_EN
         if ($urandom_range(0, 1) == 0) begin
            do_run(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, RC)) : 0, 1'($urandom));
            continue;
         end
`endif
         do_load(8, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, -1, 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
      run_start = 1'b0; abort = 1'b0;
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
      step_req = 1'b0;
`endif
      test_reset();
      do_load(8, -1, -1, 1'b0);
      do_load(8, -1, 3, 1'b0);
      do_load(8, 2, -1, 1'b0);
`ifndef CPU_RUN_CTRL_SINGLE_STEP_EN
      do_run(0, 1'b0);
      do_run(4, 1'b0);
      do_run(int'(RC), 1'b0);
      do_run(0, 1'b1);
      do_load(8, -1, -1, 1'b1);
      test_priority();
      test_reset_midrun();
`else
      test_step();
`endif
      test_reset_midload();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
